// File: rtl/cic_integrator_tdm.sv
// Time-multiplexed multi-channel CIC integrator section.
// One (channel, stage) accumulator in the shared state memory is updated per clock.
// On every DECIMATION-th accepted PDM strobe, the pass emits each channel's
// last-stage value with a one-cycle write strobe for the comb section.
module cic_integrator_tdm #(
  parameter int WIDTH      = 22,
  parameter int CHANNELS   = 8,
  parameter int STAGES     = 3,
  parameter int DECIMATION = 64
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        pdm_strobe,
  input  logic [CHANNELS-1:0]         pdm_in,
  input  logic                        clr_overrun,
  output logic                        wr_en,
  output logic [$clog2(CHANNELS)-1:0] channel,
  output logic signed [WIDTH-1:0]     data_out,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned NENT = CHANNELS * STAGES;
  localparam int unsigned IW   = $clog2(NENT);
  localparam int unsigned CW   = $clog2(CHANNELS);
  localparam int unsigned SW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned DW   = $clog2(DECIMATION);

  localparam logic [IW-1:0] LAST_IDX = IW'(NENT - 1);
  localparam logic [SW-1:0] LAST_S   = SW'(STAGES - 1);
  localparam logic [DW-1:0] LAST_DEC = DW'(DECIMATION - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic [CW-1:0]             ch_q;
  logic [SW-1:0]             s_q;
  logic [DW-1:0]             dec_q;
  logic [CHANNELS-1:0]       lat_q;
  logic signed [WIDTH-1:0]   carry_q;
  logic                      pend_q;
  logic [CW-1:0]             pend_ch_q;
  logic signed [WIDTH-1:0]   pend_dat_q;
  logic                      wr_en_q;
  logic [CW-1:0]             channel_q;
  logic signed [WIDTH-1:0]   data_q;
  logic                      busy_q;
  logic                      ovr_q;

  logic signed [WIDTH-1:0]   acc_q [NENT];

  logic signed [WIDTH-1:0]   x_d;
  logic signed [WIDTH-1:0]   sum_d;
  logic                      last_s;
  logic                      last_pair;
  logic                      emit_pass;

  // Integrator input selection and the modular (wrapping) accumulate for the current pair.
  always_comb begin
    x_d = '0;
    if (s_q == '0) begin
      x_d = lat_q[ch_q] ? WIDTH'(1) : '1;
    end else begin
      x_d = carry_q;
    end
    sum_d     = acc_q[idx_q] + x_d;
    last_s    = (s_q == LAST_S);
    last_pair = (idx_q == LAST_IDX);
    emit_pass = (dec_q == LAST_DEC);
  end

  // Shared state memory: zero-fill while clearing, accumulate while running.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      acc_q[idx_q] <= '0;
    end else if (state_q == S_RUN) begin
      acc_q[idx_q] <= sum_d;
    end
  end

  // Sequencer, decimation counter, output pipeline and sticky overrun flag.
  // The emitted value is staged in pend_* so wr_en lands one cycle after the last-stage update.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= S_CLEAR;
      idx_q      <= '0;
      ch_q       <= '0;
      s_q        <= '0;
      dec_q      <= '0;
      lat_q      <= '0;
      carry_q    <= '0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_dat_q <= '0;
      wr_en_q    <= 1'b0;
      channel_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      pend_q  <= 1'b0;
      wr_en_q <= pend_q;
      if (pend_q) begin
        channel_q <= pend_ch_q;
        data_q    <= pend_dat_q;
      end

      if (pdm_strobe && (state_q == S_RUN)) begin
        ovr_q <= 1'b1;
      end else if (clr_overrun) begin
        ovr_q <= 1'b0;
      end

      case (state_q)
        S_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (pdm_strobe) begin
            lat_q   <= pdm_in;
            idx_q   <= '0;
            ch_q    <= '0;
            s_q     <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          carry_q <= sum_d;
          if (last_s && emit_pass) begin
            pend_q     <= 1'b1;
            pend_ch_q  <= ch_q;
            pend_dat_q <= sum_d;
          end
          if (last_s) begin
            s_q  <= '0;
            ch_q <= ch_q + 1'b1;
          end else begin
            s_q <= s_q + 1'b1;
          end
          if (last_pair) begin
            idx_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dec_q   <= emit_pass ? '0 : dec_q + 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign channel  = channel_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_cic_integrator_tdm.sv
// Bench for cic_integrator_tdm: two instances (nominal and narrow wrap-around
// configuration) checked every cycle against an arithmetic CIC reference model.
module tb_cic_integrator_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic              stb_a, clr_a, stb_b, clr_b;
  logic [7:0]        pdm_a, pdm_b;
  logic              wr_a, wr_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [2:0]        ch_a, ch_b;
  logic signed [21:0] dat_a;
  logic signed [7:0]  dat_b;

  cic_integrator_tdm #(.WIDTH(22), .CHANNELS(8), .STAGES(3), .DECIMATION(4)) dut_a (
    .clk(clk), .resetn(resetn), .pdm_strobe(stb_a), .pdm_in(pdm_a), .clr_overrun(clr_a),
    .wr_en(wr_a), .channel(ch_a), .data_out(dat_a), .busy(busy_a), .overrun(ovr_a)
  );

  cic_integrator_tdm #(.WIDTH(8), .CHANNELS(8), .STAGES(1), .DECIMATION(2)) dut_b (
    .clk(clk), .resetn(resetn), .pdm_strobe(stb_b), .pdm_in(pdm_b), .clr_overrun(clr_b),
    .wr_en(wr_b), .channel(ch_b), .data_out(dat_b), .busy(busy_b), .overrun(ovr_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model parameters per instance: index 0 = dut_a, 1 = dut_b.
  int m_st [2] = '{3, 1};
  int m_dec[2] = '{4, 2};
  int m_w  [2] = '{22, 8};
  int m_n  [2] = '{24, 8};

  longint acc_m [2][8][3];
  int     cnt_m [2];
  int     run_start [2];
  int     clr_last [2];
  logic   ovr_m [2];
  int     hold_ch [2];
  longint hold_dat [2];
  int     exp_ch [int];
  longint exp_dat [int];

  function automatic longint wrapw(longint v, int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic chk(string tag, longint obs, longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d]     = 0;
      run_start[d] = -1000;
      ovr_m[d]     = 1'b0;
      hold_ch[d]   = 0;
      hold_dat[d]  = 0;
      for (int c = 0; c < 8; c++)
        for (int s = 0; s < 3; s++)
          acc_m[d][c][s] = 0;
    end
    exp_ch.delete();
    exp_dat.delete();
  endtask

  // Effect of one clock edge on instance d: strobe acceptance, integration, output schedule.
  task automatic model_edge(int d, logic stb, logic [7:0] pat, logic clr);
    logic   dropped;
    longint x;
    int     key;
    dropped = 1'b0;
    if (stb && cyc > clr_last[d]) begin
      if (cyc > run_start[d] && cyc <= run_start[d] + m_n[d]) begin
        dropped = 1'b1;
      end else begin
        run_start[d] = cyc;
        for (int c = 0; c < 8; c++) begin
          x = pat[c] ? 1 : -1;
          for (int s = 0; s < m_st[d]; s++) begin
            acc_m[d][c][s] = wrapw(acc_m[d][c][s] + x, m_w[d]);
            x = acc_m[d][c][s];
          end
          if (cnt_m[d] == m_dec[d] - 1) begin
            key = d * 1000000 + cyc + (c + 1) * m_st[d] + 1;
            exp_ch[key]  = c;
            exp_dat[key] = acc_m[d][c][m_st[d] - 1];
          end
        end
        cnt_m[d] = (cnt_m[d] + 1) % m_dec[d];
      end
    end
    if (dropped) ovr_m[d] = 1'b1;
    else if (clr) ovr_m[d] = 1'b0;
  endtask

  task automatic check_outputs(int d, logic wr, int ch, longint dat, logic bsy, logic ovr);
    int    key;
    logic  exp_wr;
    logic  exp_busy;
    string p;
    p   = (d == 0) ? "a." : "b.";
    key = d * 1000000 + cyc;
    exp_wr = 1'b0;
    if (exp_ch.exists(key)) begin
      exp_wr      = 1'b1;
      hold_ch[d]  = exp_ch[key];
      hold_dat[d] = exp_dat[key];
      exp_ch.delete(key);
      exp_dat.delete(key);
    end
    exp_busy = (cyc < clr_last[d]) || (cyc >= run_start[d] && cyc < run_start[d] + m_n[d]);
    chk({p, "wr_en"},    longint'(wr),  longint'(exp_wr));
    chk({p, "channel"},  longint'(ch),  longint'(hold_ch[d]));
    chk({p, "data_out"}, dat,           hold_dat[d]);
    chk({p, "busy"},     longint'(bsy), longint'(exp_busy));
    chk({p, "overrun"},  longint'(ovr), longint'(ovr_m[d]));
  endtask

  task automatic tick(logic sa, logic [7:0] pa, logic ca, logic sb, logic [7:0] pb);
    stb_a = sa; pdm_a = pa; clr_a = ca;
    stb_b = sb; pdm_b = pb; clr_b = 1'b0;
    @(posedge clk);
    cyc++;
    model_edge(0, sa, pa, ca);
    model_edge(1, sb, pb, 1'b0);
    #1;
    check_outputs(0, wr_a, int'(ch_a), longint'(dat_a), busy_a, ovr_a);
    check_outputs(1, wr_b, int'(ch_b), longint'(dat_b), busy_b, ovr_b);
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic strobe_a(logic [7:0] pat, int gap);
    tick(1'b1, pat, 1'b0, 1'b0, 8'h00);
    idle(gap - 1);
  endtask

  // Asserts reset, checks reset values while held, then releases and arms the clear window.
  task automatic do_reset(int hold);
    stb_a = 1'b0; pdm_a = '0; clr_a = 1'b0;
    stb_b = 1'b0; pdm_b = '0; clr_b = 1'b0;
    resetn = 1'b1;
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst.a.wr_en",    longint'(wr_a),   0);
      chk("rst.a.channel",  longint'(ch_a),   0);
      chk("rst.a.data_out", longint'(dat_a),  0);
      chk("rst.a.busy",     longint'(busy_a), 1);
      chk("rst.a.overrun",  longint'(ovr_a),  0);
      chk("rst.b.wr_en",    longint'(wr_b),   0);
      chk("rst.b.busy",     longint'(busy_b), 1);
    end
    resetn = 1'b0;
    clr_last[0] = cyc + m_n[0];
    clr_last[1] = cyc + m_n[1];
  endtask

  initial begin
    resetn = 1'b1;
    stb_a = 1'b0; pdm_a = '0; clr_a = 1'b0;
    stb_b = 1'b0; pdm_b = '0; clr_b = 1'b0;
    clr_last[0] = 0;
    clr_last[1] = 0;
    model_reset();
    do_reset(3);

    // Strobes during the clear sweep must be ignored without flagging overrun.
    idle(5);
    tick(1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF);
    idle(25);

    // All-ones: first burst 20, second burst 120.
    for (int i = 0; i < 8; i++) strobe_a(8'hFF, 30);

    // All-zeros from a clean state: -20.
    do_reset(2);
    idle(26);
    for (int i = 0; i < 4; i++) strobe_a(8'h00, 30);

    // Channel bit mapping: lower four channels +20, upper four -20.
    do_reset(2);
    idle(26);
    for (int i = 0; i < 4; i++) strobe_a(8'h0F, 30);

    // Random patterns with random legal spacing, including the minimum of 25.
    for (int i = 0; i < 16; i++) strobe_a(8'($urandom), int'($urandom_range(25, 40)));

    // Strobe in the exit cycle is dropped; the one right after is accepted.
    tick(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    idle(23);
    tick(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    tick(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    idle(30);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Overrun: 10-cycle spacing, clear coinciding with a dropped strobe, then a lone clear.
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'($urandom), (i == 2), 1'b0, 8'h00);
      idle(9);
    end
    idle(20);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    idle(5);

    // Random strobe/clear traffic at arbitrary spacing.
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 15) == 0), 1'b0, 8'h00);
    idle(30);

    // Reset at cycle 13 of an emitting pass, then a fresh burst must give 20.
    do_reset(2);
    idle(26);
    for (int i = 0; i < 3; i++) strobe_a(8'hFF, 30);
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    idle(12);
    do_reset(3);
    idle(5);
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    idle(20);
    for (int i = 0; i < 4; i++) strobe_a(8'hFF, 25);
    idle(10);

    // Wrap-around in the narrow instance: 140 all-ones strobes, mod-256 sequence.
    for (int i = 0; i < 140; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
      idle(9);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
